// File: rtl/muldiv_pkg.sv
// Shared encodings and types for the HI/LO multiply/divide engine.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the shared shift datapath: radix-2
// shift-add multiply or restoring divide on the working {hi,lo} pair.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             op,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;

  // Multiply keeps the carry of the partial sum so it shifts into hi's MSB;
  // divide trial-subtracts in WIDTH+1 bits and uses the MSB as the sign.
  always_comb begin
    mul_sum = {1'b0, hi};
    if (lo[0]) begin
      mul_sum = {1'b0, hi} + {1'b0, operand};
    end
    rem_shift = {hi, lo[WIDTH-1]};
    diff      = rem_shift - {1'b0, operand};
    next_hi   = hi;
    next_lo   = lo;
    if (op == OP_MULTU) begin
      next_hi = mul_sum[WIDTH:1];
      next_lo = {mul_sum[0], lo[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      next_hi = diff[WIDTH-1:0];
      next_lo = {lo[WIDTH-2:0], 1'b1};
    end else begin
      next_hi = rem_shift[WIDTH-1:0];
      next_lo = {lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multu/divu engine owning the architectural HI/LO
// registers; stalls mfhi/mflo while an operation is in flight.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_en,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             op_q;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic             done_q;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op      (op_q),
    .hi      (work_hi),
    .lo      (work_lo),
    .operand (operand),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  // HI/LO are touched only at the result edge, so reads during RUN see the
  // pre-operation values; start is ignored outside IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
      op_q    <= OP_MULTU;
      work_hi <= '0;
      work_lo <= '0;
      operand <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            work_hi <= '0;
            if (op == OP_DIVU && b == '0) begin
              work_lo <= a;
              operand <= b;
              hi_q    <= a;
              lo_q    <= '1;
              counter <= '0;
              done_q  <= 1'b1;
              state   <= FIN;
            end else begin
              work_lo <= (op == OP_MULTU) ? b : a;
              operand <= (op == OP_MULTU) ? a : b;
              counter <= CNT_W'(WIDTH);
              state   <= RUN;
            end
          end
        end
        RUN: begin
          work_hi <= step_hi;
          work_lo <= step_lo;
          counter <= counter - CNT_W'(1);
          if (counter == CNT_W'(1)) begin
            hi_q   <= step_hi;
            lo_q   <= step_lo;
            done_q <= 1'b1;
            state  <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign done    = done_q;
  assign stall   = busy & rd_en;
  assign rd_data = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus queues expected HI/LO and done
// cycle, a monitor pops and compares on every done pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           done_cycle;
    string        name;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         rd_en;
  logic         rd_sel;
  logic [W-1:0] rd_data;
  logic         busy;
  logic         done;
  logic         stall;

  exp_t exp_q[$];
  int   cycle_cnt;
  int   checks;
  int   errors;
  int   n_busy;

  muldiv_unit #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .rd_en   (rd_en),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .stall   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issue one operation; when track is set, queue its expected result and
  // the cycle count at which done must be observed.
  task automatic applyStimulus(input logic op_i, input logic [W-1:0] a_i,
                               input logic [W-1:0] b_i, input logic [W-1:0] exp_hi,
                               input logic [W-1:0] exp_lo, input int lat,
                               input string name, input bit track);
    exp_t e;
    @(negedge clk);
    op    = op_i;
    a     = a_i;
    b     = b_i;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (track) begin
      e.hi         = exp_hi;
      e.lo         = exp_lo;
      e.done_cycle = cycle_cnt + lat;
      e.name       = name;
      exp_q.push_back(e);
    end
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    #3;
  endtask

  // Monitor: owns rd_sel during the done cycle to read back both HI and LO.
  initial begin
    exp_t         e;
    logic [W-1:0] hi_obs;
    logic [W-1:0] lo_obs;
    int           cyc;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        cyc = cycle_cnt;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          rd_sel = 1'b1;
          #1 hi_obs = rd_data;
          rd_sel = 1'b0;
          #1 lo_obs = rd_data;
          checkOutput({e.name, "_hi"}, hi_obs, e.hi);
          checkOutput({e.name, "_lo"}, lo_obs, e.lo);
          checkOutput({e.name, "_done_cycle"}, W'(cyc), W'(e.done_cycle));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    op     = OP_MULTU;
    a      = '0;
    b      = '0;
    rd_en  = 1'b0;
    rd_sel = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle read after reset
    @(negedge clk);
    rd_en  = 1'b1;
    rd_sel = 1'b1;
    #1;
    checkOutput("idle_hi", rd_data, 32'h0);
    checkOutput("idle_stall", W'(stall), 32'd0);
    checkOutput("idle_busy", W'(busy), 32'd0);
    rd_sel = 1'b0;
    #1;
    checkOutput("idle_lo", rd_data, 32'h0);
    rd_en = 1'b0;

    applyStimulus(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000,
                  W, "mul_2p16", 1'b1);
    waitIdle(n_busy);
    checkOutput("mul_2p16_busy_cycles", W'(n_busy), 32'd33);

    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
                  W, "mul_ones", 1'b1);
    waitIdle(n_busy);

    // Divide with mid-RUN read stall and an ignored restart
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, W, "div_100_7", 1'b1);
    repeat (4) @(negedge clk);
    rd_en  = 1'b1;
    rd_sel = 1'b1;
    #1;
    checkOutput("run_stall", W'(stall), 32'd1);
    checkOutput("run_old_hi", rd_data, 32'hFFFF_FFFE);
    rd_sel = 1'b0;
    #1;
    checkOutput("run_old_lo", rd_data, 32'h0000_0001);
    op    = OP_MULTU;
    a     = 32'd50;
    b     = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rd_en = 1'b0;
    waitIdle(n_busy);
    checkOutput("div_100_7_busy_after_restart", W'(n_busy), 32'd29);

    applyStimulus(OP_DIVU, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF,
                  0, "div_by_zero", 1'b1);
    waitIdle(n_busy);
    checkOutput("div_by_zero_busy_cycles", W'(n_busy), 32'd1);

    // Asynchronous reset mid-multiply
    applyStimulus(OP_MULTU, 32'd5, 32'd7, 32'h0, 32'h0, W, "aborted", 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_n  = 1'b0;
    rd_en  = 1'b1;
    rd_sel = 1'b1;
    #1;
    checkOutput("rst_busy", W'(busy), 32'd0);
    checkOutput("rst_stall", W'(stall), 32'd0);
    checkOutput("rst_done", W'(done), 32'd0);
    checkOutput("rst_hi", rd_data, 32'h0);
    rd_sel = 1'b0;
    #1;
    checkOutput("rst_lo", rd_data, 32'h0);
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, W, "div_9_3", 1'b1);
    waitIdle(n_busy);
    checkOutput("div_9_3_busy_cycles", W'(n_busy), 32'd33);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", W'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
